// File: rtl/operand_sequencer.sv
// Operand sequencer: reads two source registers, hands them to the execute stage,
// and writes the result back. Define OPSEQ_ZERO_REG_EN to hard-wire register 0 to zero.
module operand_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       rs1,
  input  logic [3:0]       rs2,
  input  logic [3:0]       rd,
  input  logic             wb_en,
  output logic             busy,
  output logic [3:0]       rf_readreg,
  input  logic [31:0]      rf_readdata,
  output logic [3:0]       rf_writereg,
  output logic [31:0]      rf_writedata,
  output logic             rf_write_en,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic             op_valid,
  input  logic             op_ready,
  input  logic [31:0]      res_data,
  input  logic             res_valid,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, ISSUE, WAIT_RES, WB
  } state_t;

  state_t     state;
  logic [3:0] rs2_q;
  logic [3:0] rd_q;
  logic       wb_en_q;
  logic       a_zero, b_zero, d_zero;
  logic       a_zero_q, b_zero_q, d_zero_q;

  // rs1 is consumed directly when the read is issued; only its zero-ness is kept.
`ifdef OPSEQ_ZERO_REG_EN
  assign a_zero = (rs1 == '0);
  assign b_zero = (rs2 == '0);
  assign d_zero = (rd  == '0);
`else
  assign a_zero = 1'b0;
  assign b_zero = 1'b0;
  assign d_zero = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rs2_q        <= '0;
      rd_q         <= '0;
      wb_en_q      <= 1'b0;
      a_zero_q     <= 1'b0;
      b_zero_q     <= 1'b0;
      d_zero_q     <= 1'b0;
      rf_readreg   <= '0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
      rf_write_en  <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_valid     <= 1'b0;
      done         <= 1'b0;
      retired      <= '0;
    end else begin
      done        <= 1'b0;
      rf_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rs2_q      <= rs2;
            rd_q       <= rd;
            wb_en_q    <= wb_en;
            a_zero_q   <= a_zero;
            b_zero_q   <= b_zero;
            d_zero_q   <= d_zero;
            rf_readreg <= rs1;
            state      <= RD_A;
          end
        end
        RD_A: begin
          rf_readreg <= rs2_q;
          state      <= RD_B;
        end
        RD_B: begin
          op_a       <= a_zero_q ? '0 : rf_readdata;
          rf_readreg <= '0;
          state      <= CAP_B;
        end
        CAP_B: begin
          op_b     <= b_zero_q ? '0 : rf_readdata;
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            rf_writedata <= res_data;
            rf_writereg  <= rd_q;
            rf_write_en  <= wb_en_q & ~d_zero_q;
            done         <= 1'b1;
            state        <= WB;
          end
        end
        WB: begin
          retired <= retired + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port start SHALL be input, 1 bit: request to execute one instruction, sampled only in IDLE.
REQ-005 Ports rs1, rs2, rd SHALL be inputs, 4 bits each: source A, source B and destination register indices, captured with start.
REQ-006 Port wb_en SHALL be input, 1 bit: write the result back to rd, captured with start.
REQ-007 Port busy SHALL be output, 1 bit: high whenever the state is not IDLE.
REQ-008 Port rf_readreg SHALL be output, 4 bits: register-file read index; the file returns data one clock later.
REQ-009 Port rf_readdata SHALL be input, 32 bits: registered register-file read data.
REQ-010 Ports rf_writereg (4 bits), rf_writedata (32 bits) and rf_write_en (1 bit) SHALL be outputs: register-file write port.
REQ-011 Ports op_a and op_b SHALL be outputs, 32 bits each; port op_valid SHALL be output, 1 bit; port op_ready SHALL be input, 1 bit. Together these form the operand handshake to the execute stage.
REQ-012 Ports res_data (32 bits) and res_valid (1 bit) SHALL be inputs: result from the execute stage.
REQ-013 Port done SHALL be output, 1 bit: one-cycle pulse when the instruction completes.
REQ-014 Port retired SHALL be output, CNT_W bits: count of completed instructions.

Function
REQ-015 The FSM SHALL use states IDLE, RD_A, RD_B, CAP_B, ISSUE, WAIT_RES, WB.
REQ-016 In IDLE with start=1, the block SHALL latch rs1/rs2/rd/wb_en and go to RD_A; start outside IDLE SHALL be ignored.
REQ-017 In RD_A, rf_readreg SHALL equal rs1; the next state is RD_B.
REQ-018 In RD_B, rf_readreg SHALL equal rs2 and op_a SHALL capture rf_readdata at the cycle end; the next state is CAP_B.
REQ-019 In CAP_B, op_b SHALL capture rf_readdata; the next state is ISSUE.
REQ-020 In ISSUE, op_valid SHALL be 1 and op_a/op_b SHALL be held stable; on op_ready=1 the next state is WAIT_RES, otherwise the state holds indefinitely.
REQ-021 res_valid SHALL be honoured only in WAIT_RES; there it captures res_data and the next state is WB.
REQ-022 In WB, rf_write_en SHALL equal the latched wb_en for exactly one cycle, with rf_writereg=rd and rf_writedata=captured result; done=1, retired increments and wraps modulo 2^CNT_W, and the next state is IDLE.
REQ-023 Minimum latency from start to done SHALL be 6 cycles with op_ready and res_valid already high.
REQ-024 rs1=rs2 SHALL read the same register twice; op_a and op_b are then equal.
REQ-025 rf_write_en SHALL be 0 in every state except WB; rf_readreg SHALL be 0 in IDLE, ISSUE, WAIT_RES and WB.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, and drive busy=0, op_valid=0, done=0, rf_write_en=0, rf_readreg=0, rf_writereg=0, rf_writedata=0, op_a=0, op_b=0 and retired=0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no register-file write and no increment of retired.

Configuration
REQ-028 With OPSEQ_ZERO_REG_EN defined, a source index of 0 SHALL yield operand 0 regardless of rf_readdata, and rd=0 SHALL suppress rf_write_en in WB while done and retired behave normally.
REQ-029 Without OPSEQ_ZERO_REG_EN, register 0 SHALL be read and written like any other register.

Verification
REQ-030 The bench SHALL check: reg3=0x11, reg5=0x22; start rs1=3, rs2=5, rd=7, wb_en=1, op_ready=1, result 0x33 -> op_a=0x11, op_b=0x22, write 0x33 to r7, done 6 cycles after start, retired=1.
REQ-031 The bench SHALL check: op_ready low for 4 cycles in ISSUE -> op_valid held, operands stable, done delayed by 4 cycles.
REQ-032 The bench SHALL check: wb_en=0 -> done pulse and retired increments, rf_write_en never asserted.
REQ-033 The bench SHALL check: reset pulled low in WAIT_RES -> busy=0 at once, no write, retired unchanged; the next start executes normally.
REQ-034 The bench SHALL check: with OPSEQ_ZERO_REG_EN, r0 preloaded 0xDEAD, rs1=0, rd=0 -> op_a=0, no write; without the macro -> op_a=0xDEAD and r0 is written.
REQ-035 The bench SHALL check: CNT_W=4, 16 instructions -> retired wraps to 0; start held high while busy -> exactly one instruction per IDLE visit.
